// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall / flush / bubble controller for the 5-stage RV32IM pipeline.
// It arbitrates four hazard sources, highest priority first:
//   1. data-memory wait states (DMEM_BUSY)
//   2. the multi-cycle divider (DIV_START / DIV_DONE handshake)
//   3. taken-branch flushes resolved in EX
//   4. load-use data hazards between EX and ID
// Stall and flush outputs are combinational from the registered state and the
// current inputs. DIV_START and DIV_ERR are registered.
//
// Optional build macro HAZARD_PERF_CNT_EN: when defined, STALL_CYCLES and
// FLUSH_COUNT are live 32-bit wrapping counters. When undefined, both outputs
// are tied to zero and no counter flops exist.

module pipeline_hazard_ctrl #(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1_ADDR,
  input  logic [4:0]  ID_RS2_ADDR,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic        EX_MEM_READ,
  input  logic [4:0]  EX_REG_WRITE_ADDR,
  input  logic        EX_IS_DIV,
  input  logic        DIV_DONE,
  input  logic        EX_BRANCH_TAKEN,
  input  logic        DMEM_BUSY,
  output logic        DIV_START,
  output logic        PC_STALL,
  output logic        IF_ID_STALL,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_STALL,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_STALL,
  output logic        EX_MEM_FLUSH,
  output logic        MEM_WB_FLUSH,
  output logic        DIV_ERR,
  output logic [31:0] STALL_CYCLES,
  output logic [31:0] FLUSH_COUNT
);

  // One extra bit so the counter can actually hold the value DIV_TIMEOUT.
  localparam int CNT_W = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DIV_TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic             div_done_seen;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_inc;

  logic active;
  logic mem_stall;
  logic div_done;
  logic div_stall;
  logic branch_flush;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  // Saturating increment: the wait counter parks at the timeout value
  // instead of wrapping, so a hung divider keeps DIV_ERR meaningful.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_LIMIT) begin
      return CNT_LIMIT;
    end
    return cnt + CNT_W'(1);
  endfunction

  assign div_cnt_inc = cnt_sat_inc(div_cnt);

  // Every combinational control is forced low while RESET is held.
  assign active = ~RESET;

  // Memory wait states freeze the whole pipe; nothing else may act.
  assign mem_stall = active & DMEM_BUSY;

  // A done pulse that arrived while memory was busy is remembered, so the
  // divider does not have to repeat it.
  assign div_done = DIV_DONE | div_done_seen;

  // In RUN the divide instruction itself stalls for the launch cycle; in
  // DIV_WAIT the stall lasts until the result is available.
  assign div_stall = active & ~mem_stall &
                     (((state == RUN) & EX_IS_DIV) |
                      ((state == DIV_WAIT) & ~div_done));

  // A branch held in EX by a stall simply waits; it flushes on the first
  // cycle nothing above it in priority is active.
  assign branch_flush = active & ~mem_stall & ~div_stall & EX_BRANCH_TAKEN;

  // x0 is never a real producer, so a load to x0 never creates a hazard.
  assign rs1_hit  = ID_USES_RS1 & (ID_RS1_ADDR == EX_REG_WRITE_ADDR);
  assign rs2_hit  = ID_USES_RS2 & (ID_RS2_ADDR == EX_REG_WRITE_ADDR);
  assign load_use = active & ~mem_stall & ~div_stall & ~branch_flush &
                    EX_MEM_READ & (EX_REG_WRITE_ADDR != 5'd0) &
                    (rs1_hit | rs2_hit);

  // Priority-encoded stall/flush drive for the PC and pipeline registers.
  always_comb begin
    PC_STALL     = 1'b0;
    IF_ID_STALL  = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_STALL  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_STALL = 1'b0;
    EX_MEM_FLUSH = 1'b0;
    MEM_WB_FLUSH = 1'b0;
    if (mem_stall) begin
      // Hold everything up to EX/MEM and bubble WB so the stalled MEM
      // instruction is not written back twice.
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_STALL  = 1'b1;
      EX_MEM_STALL = 1'b1;
      MEM_WB_FLUSH = 1'b1;
    end else if (div_stall) begin
      // Keep the divide in EX and feed bubbles downstream until done.
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_STALL  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
    end else if (branch_flush) begin
      // Discard the two wrong-path instructions behind the branch.
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
    end else if (load_use) begin
      // Hold the consumer in ID for one cycle and bubble EX.
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
    end
  end

  // Divider sequencing FSM with launch pulse, done capture and timeout watch.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= RUN;
      div_done_seen <= 1'b0;
      div_cnt       <= '0;
      DIV_ERR       <= 1'b0;
      DIV_START     <= 1'b0;
    end else begin
      DIV_START <= 1'b0;
      if (mem_stall) begin
        // State and timeout counter frozen; the divider keeps running.
        if (DIV_DONE) begin
          div_done_seen <= 1'b1;
        end
      end else if (state == RUN) begin
        if (EX_IS_DIV) begin
          // Launch clears any stale done capture from a previous divide.
          state         <= DIV_WAIT;
          DIV_START     <= 1'b1;
          div_cnt       <= '0;
          div_done_seen <= 1'b0;
        end
      end else if (div_done) begin
        // Stalls already released this cycle so the result latches into
        // EX/MEM; the next EX_IS_DIV seen in RUN is a new instruction.
        state         <= RUN;
        div_done_seen <= 1'b0;
      end else begin
        div_cnt <= div_cnt_inc;
        if (div_cnt_inc == CNT_LIMIT) begin
          DIV_ERR <= 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Performance counters: front-end stall cycles and branch flushes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (PC_STALL) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (IF_ID_FLUSH) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign STALL_CYCLES = stall_cycles_q;
  assign FLUSH_COUNT  = flush_count_q;
`else
  assign STALL_CYCLES = 32'd0;
  assign FLUSH_COUNT  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the hazard rules. Honours HAZARD_PERF_CNT_EN.

module tb_pipeline_hazard_ctrl;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, EX_REG_WRITE_ADDR;
  logic        ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_IS_DIV;
  logic        DIV_DONE, EX_BRANCH_TAKEN, DMEM_BUSY;
  logic        DIV_START, PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL;
  logic        ID_EX_FLUSH, EX_MEM_STALL, EX_MEM_FLUSH, MEM_WB_FLUSH, DIV_ERR;
  logic [31:0] STALL_CYCLES, FLUSH_COUNT;

  int errors = 0;
  int checks = 0;

  // Model state: divide outstanding, remembered done, cycles waited,
  // sticky error, expected launch pulse, expected counter values.
  bit          m_busy, m_pend, m_err, m_start;
  int          m_wait;
  logic [31:0] m_sc, m_fc;
  bit          e_pc, e_iff;

  pipeline_hazard_ctrl #(.DIV_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_MEM_READ(EX_MEM_READ), .EX_REG_WRITE_ADDR(EX_REG_WRITE_ADDR),
    .EX_IS_DIV(EX_IS_DIV), .DIV_DONE(DIV_DONE),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .DMEM_BUSY(DMEM_BUSY),
    .DIV_START(DIV_START), .PC_STALL(PC_STALL),
    .IF_ID_STALL(IF_ID_STALL), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_STALL(ID_EX_STALL), .ID_EX_FLUSH(ID_EX_FLUSH),
    .EX_MEM_STALL(EX_MEM_STALL), .EX_MEM_FLUSH(EX_MEM_FLUSH),
    .MEM_WB_FLUSH(MEM_WB_FLUSH), .DIV_ERR(DIV_ERR),
    .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ID_RS1_ADDR = 5'd0; ID_RS2_ADDR = 5'd0; EX_REG_WRITE_ADDR = 5'd0;
    ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0; EX_MEM_READ = 1'b0;
    EX_IS_DIV = 1'b0; DIV_DONE = 1'b0; EX_BRANCH_TAKEN = 1'b0;
    DMEM_BUSY = 1'b0;
  endtask

  // Mid-cycle: compare all outputs with what the hazard rules demand now.
  task automatic eval_cycle();
    bit done, dstall, lu;
    // field order: pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f
    logic [7:0] e, got;
    logic [31:0] esc, efc;
    @(negedge CLK);
    e = 8'b0;
    if (!RESET) begin
      done   = DIV_DONE || m_pend;
      dstall = m_busy ? !done : EX_IS_DIV;
      lu     = EX_MEM_READ && (EX_REG_WRITE_ADDR != 0) &&
               ((ID_USES_RS1 && ID_RS1_ADDR == EX_REG_WRITE_ADDR) ||
                (ID_USES_RS2 && ID_RS2_ADDR == EX_REG_WRITE_ADDR));
      if (DMEM_BUSY)            e = 8'b11010101;
      else if (dstall)          e = 8'b11010010;
      else if (EX_BRANCH_TAKEN) e = 8'b00101000;
      else if (lu)              e = 8'b11001000;
    end
    e_pc  = e[7];
    e_iff = e[5];
    got = {PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_FLUSH,
           EX_MEM_STALL, EX_MEM_FLUSH, MEM_WB_FLUSH};
`ifdef HAZARD_PERF_CNT_EN
    esc = m_sc; efc = m_fc;
`else
    esc = 32'd0; efc = 32'd0;
`endif
    chk8("ctrl", got, e);
    chk1("div_start", DIV_START, m_start);
    chk1("div_err", DIV_ERR, m_err);
    chk32("stall_cycles", STALL_CYCLES, esc);
    chk32("flush_count", FLUSH_COUNT, efc);
  endtask

  // Advance the model across the coming clock edge, then step past it.
  task automatic tick();
    if (RESET) begin
      m_busy = 0; m_pend = 0; m_wait = 0; m_err = 0; m_start = 0;
      m_sc = 32'd0; m_fc = 32'd0;
    end else begin
      m_sc = m_sc + (e_pc ? 32'd1 : 32'd0);
      m_fc = m_fc + (e_iff ? 32'd1 : 32'd0);
      m_start = 0;
      if (DMEM_BUSY) begin
        if (DIV_DONE) m_pend = 1;
      end else if (!m_busy) begin
        if (EX_IS_DIV) begin
          m_busy = 1; m_start = 1; m_wait = 0; m_pend = 0;
        end
      end else if (DIV_DONE || m_pend) begin
        m_busy = 0; m_pend = 0;
      end else begin
        if (m_wait < TMO) m_wait++;
        if (m_wait >= TMO) m_err = 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      eval_cycle();
      tick();
    end
  endtask

  initial begin
    m_busy = 0; m_pend = 0; m_err = 0; m_start = 0; m_wait = 0;
    m_sc = 32'd0; m_fc = 32'd0; e_pc = 0; e_iff = 0;
    idle_in();

    // Reset with hazard-looking inputs: outputs must stay low.
    RESET = 1'b1;
    DMEM_BUSY = 1'b1; EX_IS_DIV = 1'b1;
    eval_cycle();
    chk1("rst_pc_stall", PC_STALL, 1'b0);
    chk1("rst_memwb_flush", MEM_WB_FLUSH, 1'b0);
    tick();
    idle_in();
    run(1);
    RESET = 1'b0;
    run(1);

    // Load-use on rs1 = rd = 5.
    EX_MEM_READ = 1'b1; EX_REG_WRITE_ADDR = 5'd5;
    ID_RS1_ADDR = 5'd5; ID_USES_RS1 = 1'b1;
    eval_cycle();
    chk1("lu_pc_stall", PC_STALL, 1'b1);
    chk1("lu_ifid_stall", IF_ID_STALL, 1'b1);
    chk1("lu_idex_flush", ID_EX_FLUSH, 1'b1);
    tick();
    idle_in();
    eval_cycle();
    chk1("lu_cleared", PC_STALL, 1'b0);
    tick();
    // Same pattern with rd = x0: no hazard.
    EX_MEM_READ = 1'b1; EX_REG_WRITE_ADDR = 5'd0;
    ID_RS1_ADDR = 5'd0; ID_USES_RS1 = 1'b1;
    eval_cycle();
    chk1("lu_x0_no_stall", PC_STALL, 1'b0);
    tick();
    idle_in();

    // Divide: done arrives 33 cycles after the launch pulse.
    EX_IS_DIV = 1'b1;
    eval_cycle();
    chk1("div_launch_exmem_flush", EX_MEM_FLUSH, 1'b1);
    chk1("div_launch_no_start", DIV_START, 1'b0);
    tick();
    for (int i = 1; i <= 33; i++) begin
      eval_cycle();
      chk1("div_start_pulse", DIV_START, logic'(i == 1));
      chk1("div_wait_stall", PC_STALL, 1'b1);
      tick();
    end
    DIV_DONE = 1'b1;
    eval_cycle();
    chk1("div_done_release", PC_STALL, 1'b0);
    chk1("div_done_no_bubble", EX_MEM_FLUSH, 1'b0);
    tick();
    idle_in();
    eval_cycle();
`ifdef HAZARD_PERF_CNT_EN
    chk32("perf_stall_total", STALL_CYCLES, 32'd35);
`else
    chk32("perf_stall_total", STALL_CYCLES, 32'd0);
`endif
    chk32("perf_flush_total", FLUSH_COUNT, 32'd0);
    tick();
    RESET = 1'b1;
    run(1);
    RESET = 1'b0;

    // Done pulse lands inside a 3-cycle memory wait.
    EX_IS_DIV = 1'b1;
    run(3);
    DMEM_BUSY = 1'b1; DIV_DONE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      chk1("busy_memwb_flush", MEM_WB_FLUSH, 1'b1);
      chk1("busy_exmem_stall", EX_MEM_STALL, 1'b1);
      tick();
      DIV_DONE = 1'b0;
    end
    DMEM_BUSY = 1'b0;
    eval_cycle();
    chk1("captured_done_release", PC_STALL, 1'b0);
    chk1("captured_memwb_clear", MEM_WB_FLUSH, 1'b0);
    tick();
    idle_in();
    eval_cycle();
    chk1("no_relaunch", DIV_START, 1'b0);
    tick();

    // Branch and load-use together: branch wins.
    EX_BRANCH_TAKEN = 1'b1; EX_MEM_READ = 1'b1; EX_REG_WRITE_ADDR = 5'd7;
    ID_RS2_ADDR = 5'd7; ID_USES_RS2 = 1'b1;
    eval_cycle();
    chk1("br_lu_ifid_flush", IF_ID_FLUSH, 1'b1);
    chk1("br_lu_idex_flush", ID_EX_FLUSH, 1'b1);
    chk1("br_lu_no_pc_stall", PC_STALL, 1'b0);
    tick();
    idle_in();
    // Branch held under memory wait: flush deferred.
    EX_BRANCH_TAKEN = 1'b1; DMEM_BUSY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      eval_cycle();
      chk1("br_busy_deferred", IF_ID_FLUSH, 1'b0);
      tick();
    end
    DMEM_BUSY = 1'b0;
    eval_cycle();
    chk1("br_after_busy_flush", IF_ID_FLUSH, 1'b1);
    chk1("br_after_busy_idex", ID_EX_FLUSH, 1'b1);
    tick();
    idle_in();

    // Divider timeout: no done ever arrives.
    EX_IS_DIV = 1'b1;
    run(1);
    for (int i = 1; i <= TMO; i++) begin
      eval_cycle();
      chk1("tmo_err_not_yet", DIV_ERR, 1'b0);
      tick();
    end
    eval_cycle();
    chk1("tmo_err_set", DIV_ERR, 1'b1);
    chk1("tmo_stall_held", PC_STALL, 1'b1);
    tick();
    run(2);
    RESET = 1'b1;
    eval_cycle();
    chk1("rst_mid_div_pc", PC_STALL, 1'b0);
    chk1("rst_mid_div_exmem", EX_MEM_FLUSH, 1'b0);
    tick();
    RESET = 1'b0; EX_IS_DIV = 1'b0;
    eval_cycle();
    chk1("post_rst_err", DIV_ERR, 1'b0);
    chk1("post_rst_start", DIV_START, 1'b0);
    chk1("post_rst_run", PC_STALL, 1'b0);
    tick();
    EX_IS_DIV = 1'b1;
    run(1);
    eval_cycle();
    chk1("post_rst_launch", DIV_START, 1'b1);
    tick();
    idle_in();
    RESET = 1'b1;
    run(1);
    RESET = 1'b0;

    // Randomized traffic: first half frequent done pulses, second half rare.
    for (int i = 0; i < 2000; i++) begin
      RESET             = ($urandom_range(0, 149) == 0);
      DMEM_BUSY         = ($urandom_range(0, 3) == 0);
      EX_IS_DIV         = ($urandom_range(0, 3) == 0);
      DIV_DONE          = (i < 1000) ? ($urandom_range(0, 5) == 0)
                                     : ($urandom_range(0, 29) == 0);
      EX_BRANCH_TAKEN   = ($urandom_range(0, 5) == 0);
      EX_MEM_READ       = ($urandom_range(0, 1) == 1);
      EX_REG_WRITE_ADDR = 5'($urandom_range(0, 3));
      ID_RS1_ADDR       = 5'($urandom_range(0, 3));
      ID_RS2_ADDR       = 5'($urandom_range(0, 3));
      ID_USES_RS1       = ($urandom_range(0, 1) == 1);
      ID_USES_RS2       = ($urandom_range(0, 1) == 1);
      eval_cycle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
